// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the even clock-divider sequencer:
//   - ctrl_state_e    : sequencer state encoding
//   - MIN_RATIO_DEF   : default smallest legal divide ratio
//   - ratio_is_legal(): a ratio is legal when it is even and >= the minimum
// -----------------------------------------------------------------------------
package clk_div_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_EDGE = 3'd1,
    DISABLE   = 3'd2,
    LOAD      = 3'd3,
    ENABLE    = 3'd4,
    SETTLE    = 3'd5
  } ctrl_state_e;

  localparam int unsigned MIN_RATIO_DEF = 32'd2;

  // Callers zero-extend the ratio to 32 bits so one function serves any width.
  function automatic logic ratio_is_legal(input logic [31:0] ratio,
                                          input logic [31:0] min_ratio);
    return (ratio[0] == 1'b0) && (ratio >= min_ratio);
  endfunction

endpackage

// File: rtl/clk_div_edge_det.sv
// -----------------------------------------------------------------------------
// clk_div_edge_det
// Registers the divided clock and flags its falling edge.
// Ports:
//   i_clk     : reference clock
//   i_rst     : synchronous reset, active-high
//   i_div_clk : divider output (already i_clk-synchronous)
//   o_fall    : high while the previous sample was 1 and the current one is 0
// -----------------------------------------------------------------------------
module clk_div_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_div_clk,
  output logic o_fall
);

  logic div_q;

  // One-cycle history of the divided clock.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_q <= 1'b0;
    end else begin
      div_q <= i_div_clk;
    end
  end

  // The input is already a registered signal, so this compare is glitch-free.
  assign o_fall = div_q & ~i_div_clk;

endmodule

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
// Owns the ratio/enable inputs of an even integer clock divider and changes
// them glitch-free: wait for a falling edge of the divided clock, disable,
// reload the ratio, re-enable, then report lock after one full new period.
//
// Optional build macro: CLK_DIV_CTRL_TIMEOUT_EN
//   defined   - the falling-edge wait gives up after 2*o_div_ratio cycles,
//               pulses o_timeout and forces the disable step.
//   undefined - the edge wait is unbounded and o_timeout is tied low.
//
// Ports:
//   i_clk        reference clock (also clocks the divider)
//   i_rst        synchronous reset, active-high
//   i_req_valid  ratio-change request valid
//   i_req_ratio  requested divide ratio
//   o_req_ready  controller can accept a request
//   i_div_clk    divider output (registered, i_clk-synchronous)
//   o_div_ratio  ratio driven to divider
//   o_div_en     enable driven to divider
//   o_locked     divider running at the programmed ratio
//   o_err        one-cycle pulse: illegal request rejected
//   o_timeout    one-cycle pulse: edge wait timed out
// -----------------------------------------------------------------------------
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned RATIO_WIDTH = 8,
  parameter int unsigned MIN_RATIO   = MIN_RATIO_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req_valid,
  input  logic [RATIO_WIDTH-1:0] i_req_ratio,
  output logic                   o_req_ready,
  input  logic                   i_div_clk,
  output logic [RATIO_WIDTH-1:0] o_div_ratio,
  output logic                   o_div_en,
  output logic                   o_locked,
  output logic                   o_err,
  output logic                   o_timeout
);

  localparam logic [RATIO_WIDTH-1:0] RATIO_ONE   = {{(RATIO_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [RATIO_WIDTH-1:0] RATIO_ZERO  = {RATIO_WIDTH{1'b0}};
  localparam logic [RATIO_WIDTH-1:0] RATIO_RESET = RATIO_WIDTH'(MIN_RATIO);

  ctrl_state_e            state_q;
  logic [RATIO_WIDTH-1:0] pend_q;
  logic [RATIO_WIDTH-1:0] settle_q;
  logic [RATIO_WIDTH-1:0] div_ratio_q;
  logic                   div_en_q;
  logic                   locked_q;
  logic                   ready_q;
  logic                   err_q;

  logic                   fall_s;
  logic                   req_fire_s;
  logic                   req_legal_s;
  logic                   req_same_s;

`ifdef CLK_DIV_CTRL_TIMEOUT_EN
  localparam logic [RATIO_WIDTH:0] TO_ONE  = {{RATIO_WIDTH{1'b0}}, 1'b1};
  localparam logic [RATIO_WIDTH:0] TO_ZERO = {(RATIO_WIDTH+1){1'b0}};

  logic [RATIO_WIDTH:0] to_cnt_q;
  logic [RATIO_WIDTH:0] to_limit_s;
  logic                 timeout_q;

  // Last count value of a 2*ratio cycle window; ratio >= 2 so no underflow.
  assign to_limit_s = {div_ratio_q, 1'b0} - TO_ONE;
`endif

  clk_div_edge_det u_edge_det (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_div_clk (i_div_clk),
    .o_fall    (fall_s)
  );

  // Only IDLE ever holds ready high; the state term guards against a stray
  // ready bit after an upset.
  assign req_fire_s  = i_req_valid & ready_q & (state_q == IDLE);
  assign req_legal_s = ratio_is_legal(32'(i_req_ratio), 32'(MIN_RATIO));
  assign req_same_s  = locked_q & (div_ratio_q == i_req_ratio);

  // Sequencer: handshake, legality, edge wait, disable/reload/enable, settle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      pend_q      <= RATIO_RESET;
      settle_q    <= RATIO_ZERO;
      div_ratio_q <= RATIO_RESET;
      div_en_q    <= 1'b0;
      locked_q    <= 1'b0;
      ready_q     <= 1'b1;
      err_q       <= 1'b0;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
      to_cnt_q    <= TO_ZERO;
      timeout_q   <= 1'b0;
`endif
    end else begin
      err_q <= 1'b0;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
          to_cnt_q <= TO_ZERO;
`endif
          if (req_fire_s) begin
            if (!req_legal_s) begin
              err_q <= 1'b1;
            end else if (req_same_s) begin
              // Already running locked at this ratio: nothing to do.
              ready_q <= 1'b1;
            end else begin
              pend_q   <= i_req_ratio;
              ready_q  <= 1'b0;
              locked_q <= 1'b0;
              // A stopped divider has no edge to wait for.
              state_q  <= div_en_q ? WAIT_EDGE : LOAD;
            end
          end
        end
        WAIT_EDGE: begin
          if (fall_s) begin
            state_q <= DISABLE;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
          end else if (to_cnt_q == to_limit_s) begin
            timeout_q <= 1'b1;
            state_q   <= DISABLE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_ONE;
`endif
          end
        end
        DISABLE: begin
          // Divided clock has just gone low, so stopping it cuts no pulse.
          div_en_q <= 1'b0;
          state_q  <= LOAD;
        end
        LOAD: begin
          div_ratio_q <= pend_q;
          state_q     <= ENABLE;
        end
        ENABLE: begin
          div_en_q <= 1'b1;
          settle_q <= pend_q - RATIO_ONE;
          state_q  <= SETTLE;
        end
        SETTLE: begin
          if (settle_q == RATIO_ZERO) begin
            locked_q <= 1'b1;
            ready_q  <= 1'b1;
            state_q  <= IDLE;
          end else begin
            settle_q <= settle_q - RATIO_ONE;
          end
        end
        default: begin
          // Unreachable encoding: fall back to a safe stopped, unlocked IDLE.
          div_en_q <= 1'b0;
          locked_q <= 1'b0;
          ready_q  <= 1'b1;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign o_req_ready = ready_q;
  assign o_div_ratio = div_ratio_q;
  assign o_div_en    = div_en_q;
  assign o_locked    = locked_q;
  assign o_err       = err_q;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
  assign o_timeout   = timeout_q;
`else
  assign o_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [7:0] req_ratio;
  logic       req_ready;
  logic       div_clk_s;
  logic [7:0] div_ratio;
  logic       div_en;
  logic       locked;
  logic       err;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  // Even divider model driven by the controller
  logic [7:0] dcnt;
  logic       div_clk_q;
  logic       force_low;

  // Monitor state
  logic       chk_win;
  logic [3:0] hist = 4'b0000;
  logic       en_prev = 1'b0;
  int         hi_run = 0;
  logic       to_seen = 1'b0;

  typedef struct {
    logic [7:0] ratio;
    logic       exp_err;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  clk_div_ctrl #(.RATIO_WIDTH(8), .MIN_RATIO(2)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_req_ratio (req_ratio),
    .o_req_ready (req_ready),
    .i_div_clk   (div_clk_s),
    .o_div_ratio (div_ratio),
    .o_div_en    (div_en),
    .o_locked    (locked),
    .o_err       (err),
    .o_timeout   (timeout)
  );

  // divider: toggles every ratio/2 cycles while enabled, held low when disabled
  always @(posedge clk) begin
    if (rst || !div_en) begin
      dcnt      <= 8'd0;
      div_clk_q <= 1'b0;
    end else if (dcnt == (div_ratio >> 1) - 8'd1) begin
      dcnt      <= 8'd0;
      div_clk_q <= ~div_clk_q;
    end else begin
      dcnt <= dcnt + 8'd1;
    end
  end

  assign div_clk_s = force_low ? 1'b0 : div_clk_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // glitch monitor: enable drop right after a divided-clock fall, full high pulses
  always @(negedge clk) begin
    if (chk_win) begin
      if (en_prev && !div_en)
        check("en_fall_after_div_fall", {30'd0, hist[1], hist[2]}, 32'd1);
      if (!div_clk_s && hi_run != 0)
        check("high_pulse_width", {31'd0, (hi_run == 2 || hi_run == 4)}, 32'd1);
    end
    hist    <= {hist[2:0], div_clk_s};
    en_prev <= div_en;
    hi_run  <= div_clk_s ? hi_run + 1 : 0;
    if (timeout) to_seen <= 1'b1;
  end

  task automatic measure_period(output int p);
    int   last;
    logic prev;
    last = -1;
    p    = 0;
    prev = div_clk_s;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (prev && !div_clk_s) begin
        if (last >= 0) begin
          p = i - last;
          break;
        end
        last = i;
      end
      prev = div_clk_s;
    end
  endtask

  task automatic request(input logic [7:0] r);
    req_valid = 1'b1;
    req_ratio = r;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_lock(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (locked) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic check_reset_vals(input string name);
    check(name, {25'd0, div_en, div_ratio, locked, req_ready, err},
                {25'd0, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0});
  endtask

  initial begin
    int n;
    int p;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_ratio = 8'd0;
    force_low = 1'b0;
    chk_win   = 1'b0;

    vecs[0] = '{8'd0,   1'b1};
    vecs[1] = '{8'd1,   1'b1};
    vecs[2] = '{8'd7,   1'b1};
    vecs[3] = '{8'd3,   1'b1};
    vecs[4] = '{8'd255, 1'b1};
    vecs[5] = '{8'd4,   1'b0};

    tick();
    tick();
    check_reset_vals("reset_state");
    check("reset_timeout", {31'd0, timeout}, 32'd0);
    rst = 1'b0;
    tick();

    // ratio 8 from a stopped divider
    request(8'd8);
    check("acc8_ready_low", {30'd0, req_ready, locked}, 32'd0);
    tick();
    check("edge1_ratio_en", {23'd0, div_ratio, div_en}, {23'd0, 8'd8, 1'b0});
    tick();
    check("edge2_en", {31'd0, div_en}, 32'd1);
    wait_lock(n);
    check("lock8_edge", n + 2, 32'd10);
    check("lock8_ready", {31'd0, req_ready}, 32'd1);
    measure_period(p);
    check("period8", p, 32'd8);

    // 8 -> 4 while running
    chk_win = 1'b1;
    request(8'd4);
    check("acc4_state", {29'd0, req_ready, locked, div_en}, 32'd1);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (!div_en) begin
        n = i;
        break;
      end
    end
    check("en_dropped", {31'd0, (n > 0)}, 32'd1);
    n = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (div_en) begin
        n = i;
        break;
      end
    end
    check("reenable_delay", n, 32'd2);
    check("ratio4_loaded", {24'd0, div_ratio}, 32'd4);
    wait_lock(n);
    check("lock4_after_en", n, 32'd4);
    measure_period(p);
    check("period4", p, 32'd4);
    chk_win = 1'b0;

    // illegal and same-ratio requests while locked at 4
    for (int i = 0; i < 6; i++) begin
      request(vecs[i].ratio);
      check($sformatf("vec%0d_outs", i),
            {20'd0, err, req_ready, locked, div_en, div_ratio},
            {20'd0, vecs[i].exp_err, 1'b1, 1'b1, 1'b1, 8'd4});
      tick();
      check($sformatf("vec%0d_err_clear", i), {31'd0, err}, 32'd0);
    end

    // reset while waiting for the edge
    request(8'd6);
    check("wait_edge_entered", {30'd0, req_ready, div_en}, 32'd1);
    rst = 1'b1;
    tick();
    check_reset_vals("rst_in_wait_edge");
    rst = 1'b0;
    tick();

    // reset during settle; requests with ready low are ignored
    request(8'd8);
    tick();
    tick();
    tick();
    check("settle_running", {30'd0, div_en, locked}, 32'd2);
    request(8'd0);
    check("ignored_when_busy", {30'd0, err, req_ready}, 32'd0);
    rst = 1'b1;
    tick();
    check_reset_vals("rst_in_settle");
    rst = 1'b0;
    tick();

`ifdef CLK_DIV_CTRL_TIMEOUT_EN
    request(8'd6);
    wait_lock(n);
    check("lock6", n, 32'd8);
    for (int i = 0; i < 20; i++) begin
      if (!div_clk_s) break;
      tick();
    end
    force_low = 1'b1;
    tick();
    request(8'd8);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      if (timeout) begin
        n = i - 1;
        break;
      end
      tick();
    end
    check("timeout_cycles", n, 32'd12);
    tick();
    check("timeout_one_cycle", {31'd0, timeout}, 32'd0);
    wait_lock(n);
    check("timeout_relock", {23'd0, locked, div_ratio}, {23'd0, 1'b1, 8'd8});
    force_low = 1'b0;
`else
    check("timeout_never", {31'd0, to_seen}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
